// File: rtl/mem_responder_if.sv
// mem_responder_if: datapath <-> memory responder bundle.
//   Fetch side : IReq, PCF (to memory); InstrF, IStall (to datapath).
//   Data side  : MemReadM, MemWriteM, ALUOutM, WriteDataM, ByteEnM (to memory);
//                ReadDataM, DStall (to datapath).
//   master = datapath, slave = memory responder.
interface mem_responder_if;
  logic        IReq;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic        IStall;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [3:0]  ByteEnM;
  logic [31:0] ReadDataM;
  logic        DStall;

  modport master (
    output IReq, PCF, MemReadM, MemWriteM, ALUOutM, WriteDataM, ByteEnM,
    input  InstrF, IStall, ReadDataM, DStall
  );

  modport slave (
    input  IReq, PCF, MemReadM, MemWriteM, ALUOutM, WriteDataM, ByteEnM,
    output InstrF, IStall, ReadDataM, DStall
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-port word RAM serving instruction fetches and data
// loads/stores with a fixed access latency. Data accesses win over fetches.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - mem_responder_if.slave (fetch + data request/response signals)
// Parameters:
//   ADDR_BITS - RAM holds 2^ADDR_BITS 32-bit words
//   LATENCY   - BUSY cycles per access, 1..15
module mem_responder #(
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int DEPTH     = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [2:0] {IDLE, BUSY_D, BUSY_I, RESP_D, RESP_I} state_t;

  state_t                               state;
  logic [3:0]                           cnt;
  logic [ADDR_BITS-1:0]                 daddr;
  logic [31:0]                          iaddr;   // full PCF kept for redirect compare
  logic                                 dwrite;
  logic [NUM_LANES-1:0][LANE_W-1:0]     dwdata;
  logic [NUM_LANES-1:0]                 dbe;
  logic [31:0]                          ihold;
  logic [31:0]                          dhold;

  logic                                 last_busy;
  logic                                 ram_we;
  logic [ADDR_BITS-1:0]                 acc_idx;
  logic [NUM_LANES-1:0][LANE_W-1:0]     rd_word;

  // Access happens on the edge that ends the final BUSY cycle.
  assign last_busy = ((state == BUSY_D) || (state == BUSY_I)) && (cnt == 4'd0);
  // Reset on that same edge cancels the store.
  assign ram_we    = last_busy && (state == BUSY_D) && dwrite && !reset;
  // Single port: the data address owns the RAM while a data access is busy.
  assign acc_idx   = (state == BUSY_D) ? daddr : iaddr[ADDR_BITS+1:2];

  // One byte-wide bank per lane so byte enables map to independent writes.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [LANE_W-1:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (ram_we && dbe[l])
        lane_mem[daddr] <= dwdata[l];
    end

    assign rd_word[l] = lane_mem[acc_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      daddr  <= '0;
      iaddr  <= '0;
      dwrite <= 1'b0;
      dwdata <= '0;
      dbe    <= '0;
      ihold  <= '0;
      dhold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.MemReadM || bus.MemWriteM) begin
            daddr  <= bus.ALUOutM[ADDR_BITS+1:2];
            dwdata <= bus.WriteDataM;
            dbe    <= bus.ByteEnM;
            dwrite <= bus.MemWriteM;
            cnt    <= CNT_INIT;
            state  <= BUSY_D;
          end else if (bus.IReq) begin
            iaddr <= bus.PCF;
            cnt   <= CNT_INIT;
            state <= BUSY_I;
          end
        end
        BUSY_D: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!dwrite)
              dhold <= rd_word;
            state <= RESP_D;
          end
        end
        BUSY_I: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            ihold <= rd_word;
            state <= RESP_I;
          end
        end
        // Completion, redirect and cancel all leave to IDLE; a redirected
        // fetch simply re-enters from IDLE with the new PCF.
        RESP_D:  state <= IDLE;
        RESP_I:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.IStall    = bus.IReq & ~((state == RESP_I) && (bus.PCF == iaddr));
  assign bus.DStall    = (bus.MemReadM | bus.MemWriteM) & ~(state == RESP_D);
  assign bus.InstrF    = ihold;
  assign bus.ReadDataM = dhold;

  // Address bits outside the word index are aliased away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.ALUOutM[31:ADDR_BITS+2], bus.ALUOutM[1:0]};
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder with a reference word
// model and an expected-response queue.
module tb_mem_responder;
  localparam int ADDR_BITS = 12;
  localparam int LATENCY   = 2;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] model [int];
  logic [31:0] exp_q [$];

  mem_responder_if bus ();

  mem_responder #(.ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[ADDR_BITS+1:2]);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model.exists(widx(a))) return model[widx(a)];
    return 32'h0;
  endfunction

  task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = model_rd(a);
    for (int b = 0; b < 4; b++)
      if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    model[widx(a)] = w;
  endtask

  // Data access from IDLE; counts DStall cycles and checks loaded data.
  task automatic data_access(input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             input string tag);
    int n;
    if (wr) model_wr(addr, wdata, be);
    else    exp_q.push_back(model_rd(addr));
    bus.ALUOutM    = addr;
    bus.WriteDataM = wdata;
    bus.ByteEnM    = be;
    bus.MemReadM   = !wr;
    bus.MemWriteM  = wr;
    n = 0;
    @(negedge clk);
    while (bus.DStall && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_dstall_cycles"}, 32'(n), 32'(LATENCY + 1));
    if (!wr) chk({tag, "_rdata"}, bus.ReadDataM, exp_q.pop_front());
    tick();
    bus.MemReadM  = 1'b0;
    bus.MemWriteM = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input string tag);
    int n;
    exp_q.push_back(model_rd(pc));
    bus.IReq = 1'b1;
    bus.PCF  = pc;
    n = 0;
    @(negedge clk);
    while (bus.IStall && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_istall_cycles"}, 32'(n), 32'(LATENCY + 1));
    chk({tag, "_instr"}, bus.InstrF, exp_q.pop_front());
    tick();
    bus.IReq = 1'b0;
  endtask

  initial begin
    int  ist, dst;
    bit  ddone, idone;

    reset          = 1'b1;
    bus.IReq       = 1'b1;
    bus.PCF        = 32'h0;
    bus.MemReadM   = 1'b0;
    bus.MemWriteM  = 1'b0;
    bus.ALUOutM    = 32'h0;
    bus.WriteDataM = 32'h0;
    bus.ByteEnM    = 4'h0;

    // Reset values.
    tick();
    tick();
    chk("rst_instr", bus.InstrF, 32'h0);
    chk("rst_rdata", bus.ReadDataM, 32'h0);
    chk("rst_istall", {31'b0, bus.IStall}, 32'h1);
    chk("rst_dstall_idle", {31'b0, bus.DStall}, 32'h0);
    bus.MemReadM = 1'b1;
    @(negedge clk);
    chk("rst_dstall_req", {31'b0, bus.DStall}, 32'h1);
    tick();
    reset        = 1'b0;
    bus.MemReadM = 1'b0;
    bus.IReq     = 1'b0;
    tick();

    // Seed RAM and basic store/load.
    data_access(1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, "st_w0");
    data_access(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, "st_40");
    data_access(1'b0, 32'h0000_0040, 32'h0, 4'h0, "ld_40");
    // Aliased address (upper bits and byte offset ignored).
    data_access(1'b0, 32'hF000_4043, 32'h0, 4'h0, "ld_40_alias");

    // Byte-lane store.
    data_access(1'b1, 32'h0000_0044, 32'h1122_3344, 4'hF, "st_44");
    data_access(1'b1, 32'h0000_0044, 32'hAAAA_AAAA, 4'b0100, "stb_44");
    data_access(1'b0, 32'h0000_0044, 32'h0, 4'h0, "ld_44");
    chk("ld_44_const", bus.ReadDataM, 32'h11AA_3344);

    data_access(1'b1, 32'h0000_0100, 32'h0BAD_F00D, 4'hF, "st_100");
    data_access(1'b1, 32'h0000_0200, 32'h1357_2468, 4'hF, "st_200");
    fetch(32'h0000_0100, "if_100");

    // Data and fetch raised together: data first, fetch waits.
    exp_q.push_back(model_rd(32'h40));
    exp_q.push_back(model_rd(32'h44));
    bus.ALUOutM  = 32'h40;
    bus.MemReadM = 1'b1;
    bus.IReq     = 1'b1;
    bus.PCF      = 32'h44;
    ist = 0; dst = 0; ddone = 0; idone = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (!ddone) begin
        if (bus.DStall) dst++;
        else begin
          ddone = 1;
          chk("both_dstall_cycles", 32'(dst), 32'(LATENCY + 1));
          chk("both_rdata", bus.ReadDataM, exp_q.pop_front());
        end
      end
      if (!bus.IStall) begin
        idone = 1;
        chk("both_istall_cycles", 32'(ist), 32'(2 * LATENCY + 3));
        chk("both_instr", bus.InstrF, exp_q.pop_front());
        break;
      end
      ist++;
      tick();
      if (ddone) bus.MemReadM = 1'b0;
    end
    if (!idone) chk("both_timeout", 32'h0, 32'h1);
    tick();
    bus.IReq = 1'b0;

    // Redirect while BUSY_I.
    exp_q.push_back(model_rd(32'h200));
    bus.IReq = 1'b1;
    bus.PCF  = 32'h100;
    ist = 0; idone = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc == LATENCY + 1) chk("redir_resp_i_stall", {31'b0, bus.IStall}, 32'h1);
      if (!bus.IStall) begin
        idone = 1;
        chk("redir_istall_cycles", 32'(ist), 32'(2 * LATENCY + 3));
        chk("redir_instr", bus.InstrF, exp_q.pop_front());
        break;
      end
      ist++;
      tick();
      if (cyc == 0) bus.PCF = 32'h200;
    end
    if (!idone) chk("redir_timeout", 32'h0, 32'h1);
    tick();
    bus.IReq = 1'b0;

    // Reset on the final BUSY_D edge cancels the store.
    data_access(1'b1, 32'h0000_0080, 32'h5555_5555, 4'hF, "st_80");
    data_access(1'b0, 32'h0000_0080, 32'h0, 4'h0, "ld_80_pre");
    bus.ALUOutM    = 32'h80;
    bus.WriteDataM = 32'h9999_9999;
    bus.ByteEnM    = 4'hF;
    bus.MemWriteM  = 1'b1;
    for (int i = 0; i < LATENCY; i++) tick();
    reset = 1'b1;
    tick();
    reset         = 1'b0;
    bus.MemWriteM = 1'b0;
    chk("midrst_rdata_cleared", bus.ReadDataM, 32'h0);
    data_access(1'b0, 32'h0000_0080, 32'h0, 4'h0, "ld_80_post");
    chk("ld_80_post_const", bus.ReadDataM, 32'h5555_5555);

    // Reset with a fetch of word 0 pending.
    fetch(32'h0000_0044, "if_44");
    reset    = 1'b1;
    bus.IReq = 1'b1;
    bus.PCF  = 32'h0;
    tick();
    chk("rst2_instr", bus.InstrF, 32'h0);
    chk("rst2_istall", {31'b0, bus.IStall}, 32'h1);
    reset = 1'b0;
    fetch(32'h0000_0000, "if_w0");
    chk("if_w0_const", bus.InstrF, 32'hCAFE_F00D);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
